mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage directly upstream of the write stage. Takes an executed instruction and performs
//  its load/store via a req/ready + rvalid data-memory handshake, passing everything else through.
//  Emits a one-cycle done pulse with wselector/pc/data/rd; the write stage consumes them next cycle.
//  Handles byte/half/word sizes, load sign/zero extension, store lane steering and misalignment.
// PARAMETERS
//  (none) widths fixed: XLEN 32, register index 5, wselector 4.
// PORTS
//  Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
//  clk         in   1   clock
//  rst         in   1   asynchronous reset, active-high
//  enable      in   1   one-cycle start pulse; operands below are sampled on this cycle
//  mop         in   5   [4] access, [3] store, [2] unsigned load, [1:0] size (00 B, 01 H, 10 W)
//  wsel_in     in   4   wselector for the write stage, passed through
//  pc_in       in   32  next pc, passed through
//  data_in     in   32  ALU result; effective address when mop[4]=1
//  sdata       in   32  store data (low bits used for B/H)
//  rd_in       in   5   destination register
//  done        out  1   one-cycle pulse: outputs below are valid
//  wselector   out  4   forwarded wselector (forced 0 on misalign)
//  pc          out  32  forwarded pc
//  data        out  32  load result if load, else data_in
//  rd          out  5   forwarded rd
//  misalign    out  1   valid with done: access was misaligned and was not issued
//  mem_req     out  1   request valid, held until mem_ready
//  mem_we      out  1   1 = store
//  mem_addr    out  32  word address: data_in with [1:0] = 0
//  mem_wdata   out  32  sdata replicated into lanes (B x4, H x2)
//  mem_wstrb   out  4   byte strobes from size and addr[1:0]
//  mem_ready   in   1   request accepted when mem_req && mem_ready
//  mem_rdata   in   32  load word, valid with mem_rvalid
//  mem_rvalid  in   1   load data valid, exactly one pulse per accepted load
// BEHAVIOUR
//  Reset: state IDLE, done=0, mem_req=0, mem_we=0, misalign=0, wselector=0, pc=0, data=0, rd=0,
//   mem_addr=0, mem_wdata=0, mem_wstrb=0. Reset mid-op drops mem_req and returns to IDLE.
//  FSM: IDLE, REQ, WAIT_R, DONE.
//  IDLE + enable: latch all inputs.
//   - mop[4]=0: go to DONE.
//   - misaligned (H with addr[0]=1, or W with addr[1:0]!=0): go to DONE with misalign=1,
//     wselector=0, no request.
//   - otherwise: go to REQ with mem_req=1.
//  REQ: hold mem_req/addr/wdata/wstrb/we stable until mem_ready.
//   - On acceptance, deassert mem_req that same edge.
//   - Store: go to DONE.
//   - Load: go to WAIT_R.
//  WAIT_R: on mem_rvalid, select lane by addr[1:0], sign/zero-extend per mop[2], write data,
//   go to DONE. An rvalid in the same cycle as acceptance is not possible; the bus guarantees it.
//  DONE: done=1 for exactly one cycle, outputs stable, then IDLE.
//   Outputs hold their values after done until the next completion.
//  Latency, enable to done: pass-through 1 cycle; store 1 + ready wait + 1; load adds rvalid wait.
//  Busy: enable outside IDLE is ignored. The sequencer must not issue it.
//  mem_rvalid in IDLE/REQ/DONE is ignored.
//  Strobes: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111. Loads drive wstrb=0.
// STRUCTURE
//  Shared package core_pkg:
//   - MOP_* field indices
//   - SIZE_B/H/W
//   - state encoding
//   - WSEL_* bit positions, shared with write
//  One natural sub-module, mem_lane: combinational store steering/strobe and load extract/extend.
//  The FSM and registers stay in mem_access.
// TESTING
//  1 ALU pass-through: mop=0, data_in=0x1234, rd=5, wsel=0110 -> done next cycle,
//    data=0x1234, no mem_req.
//  2 SB: addr=0x1003, sdata=0xAB, ready held low 3 cycles -> mem_req stable 4 cycles,
//    mem_addr=0x1000, wstrb=1000, wdata=0xABABABAB, done 1 cycle after accept.
//  3 LB signed vs LBU: rdata=0x80FF0000, addr offset 3 -> data=0xFFFFFF80 and 0x00000080.
//  4 LH: addr=0x2002, rdata=0x8001_0000, rvalid 5 cycles late -> data=0xFFFF8001,
//    done exactly once.
//  5 LW at addr=0x3002 -> no mem_req, done next cycle, misalign=1, wselector=0.
//  6 rst pulsed while in WAIT_R -> mem_req=0, IDLE. Late rvalid is ignored.
//    The next enable completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: micro-op field layout, access sizes, memory FSM states
// and the write-selector bit positions that the write stage also decodes.
package core_pkg;
    localparam int MOP_ACC = 4;
    localparam int MOP_ST  = 3;
    localparam int MOP_UNS = 2;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int WSEL_REG = 0;
    localparam int WSEL_CSR = 1;
    localparam int WSEL_PC  = 2;
    localparam int WSEL_MEM = 3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} mem_state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic for the memory stage: store replication/strobes and load
// lane extraction with sign or zero extension.
module mem_lane
    import core_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        zext,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ldata
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        wdata   = sdata;
        wstrb   = 4'b1111;
        ldata   = shifted;
        case (size)
            SIZE_B: begin
                wdata = {4{sdata[7:0]}};
                wstrb = 4'b0001 << offset;
                ldata = {{24{~zext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wdata = {2{sdata[15:0]}};
                wstrb = 4'b0011 << offset;
                ldata = {{16{~zext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores over a req/ready + rvalid bus and hands a
// one-cycle done pulse with the write-back fields to the write stage.
module mem_access
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [4:0]  mop,
    input  logic [3:0]  wsel_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] data_in,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd_in,
    output logic        done,
    output logic [3:0]  wselector,
    output logic [31:0] pc,
    output logic [31:0] data,
    output logic [4:0]  rd,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    mem_state_t  state, state_nxt;
    logic [4:0]  op_mop;
    logic [3:0]  op_wsel;
    logic [31:0] op_pc, op_addr, op_sdata;
    logic [4:0]  op_rd;
    logic [31:0] lane_wdata, lane_ldata;
    logic [3:0]  lane_wstrb;
    logic        in_mis;

    assign in_mis = misaligned(mop[1:0], data_in[1:0]);

    // Bus fields come straight from the latched op, so they are stable for all of REQ.
    assign mem_req   = (state == REQ);
    assign done      = (state == DONE);
    assign mem_we    = op_mop[MOP_ACC] & op_mop[MOP_ST];
    assign mem_addr  = {op_addr[31:2], 2'b00};
    assign mem_wdata = lane_wdata;
    assign mem_wstrb = mem_we ? lane_wstrb : 4'b0000;

    mem_lane u_lane (
        .size   (op_mop[1:0]),
        .offset (op_addr[1:0]),
        .zext   (op_mop[MOP_UNS]),
        .sdata  (op_sdata),
        .rdata  (mem_rdata),
        .wdata  (lane_wdata),
        .wstrb  (lane_wstrb),
        .ldata  (lane_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) begin
                if (!mop[MOP_ACC] || in_mis) state_nxt = DONE;
                else                         state_nxt = REQ;
            end
            REQ:    if (mem_ready) state_nxt = op_mop[MOP_ST] ? DONE : WAIT_R;
            WAIT_R: if (mem_rvalid) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output fields only change on the edge into DONE and hold until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_mop <= '0; op_wsel <= '0; op_pc <= '0; op_addr <= '0; op_sdata <= '0; op_rd <= '0;
            wselector <= '0; pc <= '0; data <= '0; rd <= '0; misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    op_mop <= mop; op_wsel <= wsel_in; op_pc <= pc_in;
                    op_addr <= data_in; op_sdata <= sdata; op_rd <= rd_in;
                    if (!mop[MOP_ACC] || in_mis) begin
                        wselector <= (mop[MOP_ACC] && in_mis) ? 4'b0000 : wsel_in;
                        misalign  <= mop[MOP_ACC] && in_mis;
                        pc <= pc_in; data <= data_in; rd <= rd_in;
                    end
                end
                REQ: if (mem_ready && op_mop[MOP_ST]) begin
                    wselector <= op_wsel; misalign <= 1'b0;
                    pc <= op_pc; data <= op_addr; rd <= op_rd;
                end
                WAIT_R: if (mem_rvalid) begin
                    wselector <= op_wsel; misalign <= 1'b0;
                    pc <= op_pc; data <= lane_ldata; rd <= op_rd;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, stores, signed/unsigned loads,
// misalignment and reset in the middle of a load.
module tb_mem_access;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [4:0]  mop = '0, rd_in = '0;
    logic [3:0]  wsel_in = '0;
    logic [31:0] pc_in = '0, data_in = '0, sdata = '0;
    logic        done, misalign, mem_req, mem_we;
    logic [3:0]  wselector, mem_wstrb;
    logic [31:0] pc, data, mem_addr, mem_wdata;
    logic [4:0]  rd;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .enable(enable), .mop(mop), .wsel_in(wsel_in),
        .pc_in(pc_in), .data_in(data_in), .sdata(sdata), .rd_in(rd_in),
        .done(done), .wselector(wselector), .pc(pc), .data(data), .rd(rd),
        .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [4:0] m, input logic [31:0] a, input logic [31:0] sd,
                         input logic [3:0] ws, input logic [4:0] r, input logic [31:0] p);
        enable = 1'b1; mop = m; data_in = a; sdata = sd; wsel_in = ws; rd_in = r; pc_in = p;
        tick();
        enable = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [4:0] m, input logic [31:0] a,
                            input logic [31:0] sd, input int rwait,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
        issue(m, a, sd, 4'b0001, 5'd3, 32'h200);
        repeat (rwait) begin
            chk({tag, ".req_wait"}, mem_req, 1);
            chk({tag, ".addr_wait"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, ".nodone"}, done, 0);
            tick();
        end
        chk({tag, ".req"}, mem_req, 1);
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        chk({tag, ".wstrb"}, mem_wstrb, exp_strb);
        chk({tag, ".we"}, mem_we, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".req_drop"}, mem_req, 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".data"}, data, a);
        chk({tag, ".wsel"}, wselector, 4'b0001);
        chk({tag, ".pc"}, pc, 32'h200);
        tick();
        chk({tag, ".done_once"}, done, 0);
    endtask

    task automatic do_load(input string tag, input logic [4:0] m, input logic [31:0] a,
                           input logic [31:0] rdat, input int rwait, input logic [31:0] exp);
        issue(m, a, 32'hFFFF_FFFF, 4'b1000, 5'd7, 32'h44);
        chk({tag, ".req"}, mem_req, 1);
        chk({tag, ".we"}, mem_we, 0);
        chk({tag, ".wstrb"}, mem_wstrb, 0);
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".req_drop"}, mem_req, 0);
        repeat (rwait) begin
            chk({tag, ".nodone"}, done, 0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".data"}, data, exp);
        chk({tag, ".rd"}, rd, 7);
        chk({tag, ".wsel"}, wselector, 4'b1000);
        chk({tag, ".misalign"}, misalign, 0);
        tick();
        chk({tag, ".done_once"}, done, 0);
        chk({tag, ".hold"}, data, exp);
    endtask

    initial begin
        #3;
        chk("rst.done", done, 0);
        chk("rst.req", mem_req, 0);
        chk("rst.data", data, 0);
        chk("rst.pc", pc, 0);
        chk("rst.wstrb", mem_wstrb, 0);
        chk("rst.addr", mem_addr, 0);
        #9 rst = 1'b0;
        tick();

        // ALU pass-through
        issue(5'b00000, 32'h1234, 32'h0, 4'b0110, 5'd5, 32'h1000);
        chk("alu.done", done, 1);
        chk("alu.data", data, 32'h1234);
        chk("alu.rd", rd, 5);
        chk("alu.wsel", wselector, 4'b0110);
        chk("alu.pc", pc, 32'h1000);
        chk("alu.req", mem_req, 0);
        tick();
        chk("alu.done_once", done, 0);
        chk("alu.req2", mem_req, 0);

        do_store("sb", 5'b11000, 32'h1003, 32'h0000_00AB, 3, 32'hABAB_ABAB, 4'b1000);
        do_store("sh", 5'b11001, 32'h2006, 32'h1234_BEEF, 0, 32'hBEEF_BEEF, 4'b1100);

        do_load("lb",  5'b10000, 32'h1003, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        do_load("lbu", 5'b10100, 32'h1003, 32'h80FF_0000, 0, 32'h0000_0080);
        do_load("lh",  5'b10001, 32'h2002, 32'h8001_0000, 5, 32'hFFFF_8001);

        // misaligned word load
        issue(5'b10010, 32'h3002, 32'h0, 4'b1000, 5'd9, 32'h300);
        chk("mis.req", mem_req, 0);
        chk("mis.done", done, 1);
        chk("mis.flag", misalign, 1);
        chk("mis.wsel", wselector, 0);
        tick();
        chk("mis.done_once", done, 0);
        chk("mis.req2", mem_req, 0);

        // reset while waiting for read data
        issue(5'b10010, 32'h4000, 32'h0, 4'b1000, 5'd7, 32'h44);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("rstmid.req", mem_req, 0);
        chk("rstmid.done", done, 0);
        chk("rstmid.data", data, 0);
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        chk("rstmid.late_rvalid", done, 0);
        chk("rstmid.req2", mem_req, 0);
        tick();
        chk("rstmid.idle", done, 0);
        do_load("lw_after", 5'b10010, 32'h4004, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
